// File: rtl/instr_byte_assembler.sv
// Assembles one 8088 instruction record (prefixes, opcode, ModRM, disp, imm) from the
// prefetch queue, one byte per two cycles, and hands it to the execution unit.
module instr_byte_assembler #(
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                 CLKx4,
  input  logic                 RESET,
  input  logic [7:0]           prefetchTop,
  input  logic [19:0]          prefetchTopLinearAddress,
  input  logic                 prefetchEmpty,
  output logic                 advanceTop,
  input  logic                 flush,
  output logic [7:0]           lookupOpcode,
  input  logic                 lookupModRM,
  input  logic [2:0]           lookupImmBytes,
  output logic                 instrValid,
  input  logic                 instrAccept,
  output logic                 segOverrideValid,
  output logic [2:0]           segOverride,
  output logic [1:0]           repPrefix,
  output logic                 lockPrefix,
  output logic [7:0]           opcode,
  output logic [7:0]           modrm,
  output logic [15:0]          disp,
  output logic [31:0]          imm,
  output logic [19:0]          instrLinearAddress,
  output logic [LEN_WIDTH-1:0] instrLength
);

  typedef enum logic [2:0] {
    StFetchOp,
    StFetchModrm,
    StFetchDisp,
    StFetchImm,
    StGap,
    StValid
  } state_e;

  // Remembers what the byte before the current gap was, so the gap knows where to go.
  typedef enum logic [1:0] {
    LastPrefix,
    LastOpcode,
    LastOther
  } last_e;

  localparam logic [LEN_WIDTH-1:0] LenMax = '1;
  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  last_e                last_q, last_d;
  logic                 adv_q, adv_d;
  logic                 seg_valid_q, seg_valid_d;
  logic [1:0]           seg_q, seg_d;
  logic [1:0]           rep_q, rep_d;
  logic                 lock_q, lock_d;
  logic [7:0]           opcode_q, opcode_d;
  logic [7:0]           modrm_q, modrm_d;
  logic [15:0]          disp_q, disp_d;
  logic [31:0]          imm_q, imm_d;
  logic [19:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [1:0]           disp_left_q, disp_left_d;
  logic                 disp_two_q, disp_two_d;
  logic [2:0]           imm_left_q, imm_left_d;
  logic [1:0]           imm_idx_q, imm_idx_d;

  logic                 fetching;
  logic                 is_seg;
  logic                 is_rep;
  logic                 is_lock;
  logic [2:0]           rom_imm;
  logic [1:0]           modrm_disp;
  logic [LEN_WIDTH-1:0] len_inc;
  state_e               after_field;

  assign fetching = (state_q == StFetchOp) || (state_q == StFetchModrm) ||
                    (state_q == StFetchDisp) || (state_q == StFetchImm);
  assign is_seg   = (prefetchTop == 8'h26) || (prefetchTop == 8'h2E) ||
                    (prefetchTop == 8'h36) || (prefetchTop == 8'h3E);
  assign is_rep   = (prefetchTop == 8'hF2) || (prefetchTop == 8'hF3);
  assign is_lock  = (prefetchTop == 8'hF0);
  assign rom_imm  = (lookupImmBytes > 3'd4) ? 3'd4 : lookupImmBytes;
  assign len_inc  = (len_q == LenMax) ? len_q : len_q + LenOne;

  always_comb begin
    modrm_disp = 2'd0;
    unique case (prefetchTop[7:6])
      2'b00:   modrm_disp = (prefetchTop[2:0] == 3'b110) ? 2'd2 : 2'd0;
      2'b01:   modrm_disp = 2'd1;
      2'b10:   modrm_disp = 2'd2;
      default: modrm_disp = 2'd0;
    endcase
  end

  always_comb begin
    after_field = StValid;
    if (disp_left_q != 2'd0) begin
      after_field = StFetchDisp;
    end else if (imm_left_q != 3'd0) begin
      after_field = StFetchImm;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    adv_d       = 1'b0;
    seg_valid_d = seg_valid_q;
    seg_d       = seg_q;
    rep_d       = rep_q;
    lock_d      = lock_q;
    opcode_d    = opcode_q;
    modrm_d     = modrm_q;
    disp_d      = disp_q;
    imm_d       = imm_q;
    addr_d      = addr_q;
    len_d       = len_q;
    disp_left_d = disp_left_q;
    disp_two_d  = disp_two_q;
    imm_left_d  = imm_left_q;
    imm_idx_d   = imm_idx_q;

    if (flush) begin
      state_d     = StFetchOp;
      last_d      = LastOther;
      seg_valid_d = 1'b0;
      seg_d       = 2'd0;
      rep_d       = 2'd0;
      lock_d      = 1'b0;
      opcode_d    = 8'h00;
      modrm_d     = 8'h00;
      disp_d      = 16'h0000;
      imm_d       = 32'h0000_0000;
      addr_d      = 20'h00000;
      len_d       = '0;
      disp_left_d = 2'd0;
      disp_two_d  = 1'b0;
      imm_left_d  = 3'd0;
      imm_idx_d   = 2'd0;
    end else begin
      // Every fetch state shares the pop strobe, the gap and the length count.
      if (fetching && !prefetchEmpty) begin
        adv_d   = 1'b1;
        state_d = StGap;
        len_d   = len_inc;
        last_d  = LastOther;
      end

      unique case (state_q)
        StFetchOp: begin
          if (!prefetchEmpty) begin
            if (len_q == '0) begin
              addr_d = prefetchTopLinearAddress;
            end
            if (is_seg) begin
              seg_valid_d = 1'b1;
              seg_d       = prefetchTop[4:3];
              last_d      = LastPrefix;
            end else if (is_rep) begin
              rep_d  = {1'b1, prefetchTop[0]};
              last_d = LastPrefix;
            end else if (is_lock) begin
              lock_d = 1'b1;
              last_d = LastPrefix;
            end else begin
              opcode_d = prefetchTop;
              last_d   = LastOpcode;
            end
          end
        end
        StFetchModrm: begin
          if (!prefetchEmpty) begin
            modrm_d     = prefetchTop;
            disp_left_d = modrm_disp;
            disp_two_d  = (modrm_disp == 2'd2);
          end
        end
        StFetchDisp: begin
          if (!prefetchEmpty) begin
            if (!disp_two_q) begin
              disp_d = {{8{prefetchTop[7]}}, prefetchTop};
            end else if (disp_left_q == 2'd2) begin
              disp_d[7:0] = prefetchTop;
            end else begin
              disp_d[15:8] = prefetchTop;
            end
            disp_left_d = disp_left_q - 2'd1;
          end
        end
        StFetchImm: begin
          if (!prefetchEmpty) begin
            imm_d[{imm_idx_q, 3'b000} +: 8] = prefetchTop;
            imm_idx_d  = imm_idx_q + 2'd1;
            imm_left_d = imm_left_q - 3'd1;
          end
        end
        StGap: begin
          unique case (last_q)
            LastPrefix: state_d = StFetchOp;
            LastOpcode: begin
              // The ROM output is valid now: opcode has been stable for a full cycle.
              imm_left_d = rom_imm;
              imm_idx_d  = 2'd0;
              if (lookupModRM) begin
                state_d = StFetchModrm;
              end else if (rom_imm != 3'd0) begin
                state_d = StFetchImm;
              end else begin
                state_d = StValid;
              end
            end
            default: state_d = after_field;
          endcase
        end
        StValid: begin
          if (instrAccept) begin
            state_d     = StFetchOp;
            seg_valid_d = 1'b0;
            seg_d       = 2'd0;
            rep_d       = 2'd0;
            lock_d      = 1'b0;
            modrm_d     = 8'h00;
            disp_d      = 16'h0000;
            imm_d       = 32'h0000_0000;
            len_d       = '0;
            disp_left_d = 2'd0;
            disp_two_d  = 1'b0;
            imm_left_d  = 3'd0;
            imm_idx_d   = 2'd0;
          end
        end
        default: state_d = StFetchOp;
      endcase
    end
  end

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      state_q     <= StFetchOp;
      last_q      <= LastOther;
      adv_q       <= 1'b0;
      seg_valid_q <= 1'b0;
      seg_q       <= 2'd0;
      rep_q       <= 2'd0;
      lock_q      <= 1'b0;
      opcode_q    <= 8'h00;
      modrm_q     <= 8'h00;
      disp_q      <= 16'h0000;
      imm_q       <= 32'h0000_0000;
      addr_q      <= 20'h00000;
      len_q       <= '0;
      disp_left_q <= 2'd0;
      disp_two_q  <= 1'b0;
      imm_left_q  <= 3'd0;
      imm_idx_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      adv_q       <= adv_d;
      seg_valid_q <= seg_valid_d;
      seg_q       <= seg_d;
      rep_q       <= rep_d;
      lock_q      <= lock_d;
      opcode_q    <= opcode_d;
      modrm_q     <= modrm_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      disp_left_q <= disp_left_d;
      disp_two_q  <= disp_two_d;
      imm_left_q  <= imm_left_d;
      imm_idx_q   <= imm_idx_d;
    end
  end

  assign advanceTop         = adv_q;
  assign lookupOpcode       = opcode_q;
  assign instrValid         = (state_q == StValid);
  assign segOverrideValid   = seg_valid_q;
  assign segOverride        = {1'b0, seg_q};
  assign repPrefix          = rep_q;
  assign lockPrefix         = lock_q;
  assign opcode             = opcode_q;
  assign modrm              = modrm_q;
  assign disp               = disp_q;
  assign imm                = imm_q;
  assign instrLinearAddress = addr_q;
  assign instrLength        = len_q;

endmodule

// File: tb/tb_instr_byte_assembler.sv
// Directed bench for instr_byte_assembler: a small prefetch-queue model and decode ROM
// feed hand-picked byte streams; each record field is checked against hand-computed values.
module tb_instr_byte_assembler;

  logic        CLKx4;
  logic        RESET;
  logic [7:0]  prefetchTop;
  logic [19:0] prefetchTopLinearAddress;
  logic        prefetchEmpty;
  logic        advanceTop;
  logic        flush;
  logic [7:0]  lookupOpcode;
  logic        lookupModRM;
  logic [2:0]  lookupImmBytes;
  logic        instrValid;
  logic        instrAccept;
  logic        segOverrideValid;
  logic [2:0]  segOverride;
  logic [1:0]  repPrefix;
  logic        lockPrefix;
  logic [7:0]  opcode;
  logic [7:0]  modrm;
  logic [15:0] disp;
  logic [31:0] imm;
  logic [19:0] instrLinearAddress;
  logic [3:0]  instrLength;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] qmem [64];
  int head = 0;
  int tail = 0;
  int base = 0;
  logic hold_empty = 1'b0;
  int pulses = 0;
  int adv_double = 0;
  logic adv_prev = 1'b0;
  int cyc;
  int p0;

  instr_byte_assembler #(.LEN_WIDTH(4)) dut (
    .CLKx4                    (CLKx4),
    .RESET                    (RESET),
    .prefetchTop              (prefetchTop),
    .prefetchTopLinearAddress (prefetchTopLinearAddress),
    .prefetchEmpty            (prefetchEmpty),
    .advanceTop               (advanceTop),
    .flush                    (flush),
    .lookupOpcode             (lookupOpcode),
    .lookupModRM              (lookupModRM),
    .lookupImmBytes           (lookupImmBytes),
    .instrValid               (instrValid),
    .instrAccept              (instrAccept),
    .segOverrideValid         (segOverrideValid),
    .segOverride              (segOverride),
    .repPrefix                (repPrefix),
    .lockPrefix               (lockPrefix),
    .opcode                   (opcode),
    .modrm                    (modrm),
    .disp                     (disp),
    .imm                      (imm),
    .instrLinearAddress       (instrLinearAddress),
    .instrLength              (instrLength)
  );

  initial begin
    CLKx4 = 1'b0;
    forever #5 CLKx4 = ~CLKx4;
  end

  assign prefetchTop              = qmem[head];
  assign prefetchTopLinearAddress = 20'(base + head);
  assign prefetchEmpty            = (head == tail) || hold_empty;

  // Decode ROM model: 05 deliberately reports 7 immediate bytes.
  always_comb begin
    lookupModRM    = 1'b0;
    lookupImmBytes = 3'd0;
    case (lookupOpcode)
      8'h8B:   lookupModRM = 1'b1;
      8'hEA:   lookupImmBytes = 3'd4;
      8'hB8:   lookupImmBytes = 3'd2;
      8'h05:   lookupImmBytes = 3'd7;
      default: lookupImmBytes = 3'd0;
    endcase
  end

  // Queue pops on the rising edge of advanceTop.
  always @(negedge CLKx4) begin
    if (advanceTop && adv_prev) adv_double = adv_double + 1;
    if (advanceTop && !adv_prev) begin
      pulses = pulses + 1;
      if (head < tail) head = head + 1;
    end
    adv_prev = advanceTop;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    qmem[tail] = b;
    tail = tail + 1;
  endtask

  task automatic tick();
    @(posedge CLKx4);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (instrValid === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic accept();
    instrAccept = 1'b1;
    tick();
    instrAccept = 1'b0;
  endtask

  initial begin
    RESET       = 1'b1;
    flush       = 1'b0;
    instrAccept = 1'b0;
    base        = 32'h10000;
    repeat (3) tick();
    check("rst_valid", 32'(instrValid), 0);
    check("rst_adv", 32'(advanceTop), 0);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_len", 32'(instrLength), 0);
    check("rst_addr", 32'(instrLinearAddress), 0);
    RESET = 1'b0;
    tick();

    // Single-byte NOP
    push(8'h90);
    tick();
    check("nop_adv_hi", 32'(advanceTop), 1);
    check("nop_valid_early", 32'(instrValid), 0);
    tick();
    check("nop_valid", 32'(instrValid), 1);
    check("nop_adv_lo", 32'(advanceTop), 0);
    check("nop_opcode", 32'(opcode), 32'h90);
    check("nop_len", 32'(instrLength), 1);
    check("nop_addr", 32'(instrLinearAddress), 32'h10000);
    check("nop_modrm", 32'(modrm), 0);
    check("nop_imm", imm, 0);
    check("nop_seg", 32'(segOverrideValid), 0);
    check("nop_pulses", 32'(pulses), 1);
    accept();
    check("nop_accept", 32'(instrValid), 0);

    // CS: MOV AX,[BX-2]
    p0 = pulses;
    push(8'h2E); push(8'h8B); push(8'h47); push(8'hFE);
    wait_valid(40, cyc);
    check("mov_lat", 32'(cyc), 8);
    check("mov_segv", 32'(segOverrideValid), 1);
    check("mov_seg", 32'(segOverride), 1);
    check("mov_opcode", 32'(opcode), 32'h8B);
    check("mov_modrm", 32'(modrm), 32'h47);
    check("mov_disp", 32'(disp), 32'hFFFE);
    check("mov_len", 32'(instrLength), 4);
    check("mov_addr", 32'(instrLinearAddress), 32'h10001);
    check("mov_pulses", 32'(pulses - p0), 4);
    check("mov_double", 32'(adv_double), 0);
    accept();

    // JMP FAR F000:0100
    push(8'hEA); push(8'h00); push(8'h01); push(8'h00); push(8'hF0);
    wait_valid(40, cyc);
    check("jmp_lat", 32'(cyc), 10);
    check("jmp_imm", imm, 32'hF000_0100);
    check("jmp_len", 32'(instrLength), 5);
    check("jmp_disp", 32'(disp), 0);
    check("jmp_segv", 32'(segOverrideValid), 0);
    accept();

    // REP MOVSB then an empty stretch before MOV AX,1234
    push(8'hF3); push(8'hA4);
    wait_valid(40, cyc);
    check("rep_lat", 32'(cyc), 4);
    check("rep_rep", 32'(repPrefix), 3);
    check("rep_opcode", 32'(opcode), 32'hA4);
    check("rep_len", 32'(instrLength), 2);
    check("rep_addr", 32'(instrLinearAddress), 32'h1000A);
    accept();
    hold_empty = 1'b1;
    p0 = pulses;
    push(8'hB8); push(8'h34); push(8'h12);
    repeat (10) tick();
    check("empty_pulses", 32'(pulses - p0), 0);
    hold_empty = 1'b0;
    wait_valid(40, cyc);
    check("movi_lat", 32'(cyc), 6);
    check("movi_imm", imm, 32'h0000_1234);
    check("movi_rep", 32'(repPrefix), 0);
    check("movi_len", 32'(instrLength), 3);
    check("movi_addr", 32'(instrLinearAddress), 32'h1000C);

    // Hold the record with more bytes waiting: no pops, stable fields
    p0 = pulses;
    push(8'h8B); push(8'h87); push(8'h34); push(8'h12);
    repeat (6) tick();
    check("hold_valid", 32'(instrValid), 1);
    check("hold_pulses", 32'(pulses - p0), 0);
    check("hold_imm", imm, 32'h0000_1234);
    check("hold_len", 32'(instrLength), 3);
    accept();
    check("hold_accept", 32'(instrValid), 0);
    check("hold_adv_lo", 32'(advanceTop), 0);
    tick();
    check("next_fetch_adv", 32'(advanceTop), 1);

    // Flush while waiting for the displacement
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_adv", 32'(advanceTop), 0);
    check("flush_valid", 32'(instrValid), 0);
    check("flush_modrm", 32'(modrm), 0);
    check("flush_disp", 32'(disp), 0);
    check("flush_len", 32'(instrLength), 0);
    check("flush_pulses", 32'(pulses - p0), 2);
    head = tail;
    base = 32'h20000 - tail;
    push(8'hC3);
    wait_valid(40, cyc);
    check("ret_lat", 32'(cyc), 2);
    check("ret_opcode", 32'(opcode), 32'hC3);
    check("ret_len", 32'(instrLength), 1);
    check("ret_addr", 32'(instrLinearAddress), 32'h20000);
    check("ret_modrm", 32'(modrm), 0);
    check("ret_disp", 32'(disp), 0);

    // Reset in the middle of a pop
    push(8'h2E); push(8'h90);
    accept();
    tick();
    check("pre_rst_adv", 32'(advanceTop), 1);
    check("pre_rst_segv", 32'(segOverrideValid), 1);
    RESET = 1'b1;
    tick();
    check("mid_rst_adv", 32'(advanceTop), 0);
    check("mid_rst_segv", 32'(segOverrideValid), 0);
    check("mid_rst_addr", 32'(instrLinearAddress), 0);
    check("mid_rst_len", 32'(instrLength), 0);
    check("mid_rst_opcode", 32'(opcode), 0);
    RESET = 1'b0;
    head = tail;
    base = 32'h30000 - tail;

    // 15 prefixes + opcode: length saturates, last segment prefix wins
    for (int i = 0; i < 12; i++) push(8'h26);
    push(8'hF0); push(8'hF2); push(8'h3E); push(8'h90);
    wait_valid(60, cyc);
    check("sat_lat", 32'(cyc), 32);
    check("sat_len", 32'(instrLength), 15);
    check("sat_seg", 32'(segOverride), 3);
    check("sat_rep", 32'(repPrefix), 2);
    check("sat_lock", 32'(lockPrefix), 1);
    check("sat_addr", 32'(instrLinearAddress), 32'h30000);
    accept();

    // ROM immediate count above 4 is clamped to 4
    push(8'h05); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid(40, cyc);
    check("clamp_lat", 32'(cyc), 10);
    check("clamp_imm", imm, 32'h4433_2211);
    check("clamp_len", 32'(instrLength), 5);
    check("clamp_lock", 32'(lockPrefix), 0);
    check("clamp_addr", 32'(instrLinearAddress), 32'h30010);
    accept();
    check("clamp_accept", 32'(instrValid), 0);
    check("end_double", 32'(adv_double), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_byte_assembler.md
Name: instr_byte_assembler

Overview:
Consumes bytes from the bus interface prefetch queue and assembles one complete 8088 instruction record per handshake. The record holds prefixes, opcode, ModRM, displacement, immediate, start linear address and byte length. Opcode length class comes from an external combinational decode ROM. The block sits between the prefetch queue (prefetchTop/prefetchEmpty/advanceTop) and the execution unit.

Parameters:
LEN_WIDTH, 4, width of the instruction length field; the length counter saturates at 2^LEN_WIDTH-1.

Ports:
CLKx4  in  1  system clock
RESET  in  1  synchronous, active-high reset
prefetchTop  in  8  byte at the queue head
prefetchTopLinearAddress  in  20  linear address of the head byte
prefetchEmpty  in  1  queue empty (includes HOLDA)
advanceTop  out  1  pop strobe; the queue pops on its 0->1 edge
flush  in  1  abort the instruction being assembled
lookupOpcode  out  8  opcode presented to the decode ROM
lookupModRM  in  1  ROM: opcode has a ModRM byte
lookupImmBytes  in  3  ROM: immediate byte count, 0..4
instrValid  out  1  record valid
instrAccept  in  1  execution unit takes the record
segOverrideValid  out  1  a segment prefix was seen
segOverride  out  3  ES=0, CS=1, SS=2, DS=3 (indirectSeg encoding)
repPrefix  out  2  00 none, 10 REPNE (F2), 11 REP (F3)
lockPrefix  out  1  F0 seen
opcode  out  8  opcode byte
modrm  out  8  ModRM byte (0 if absent)
disp  out  16  displacement, sign-extended when 1 byte
imm  out  32  immediate, little-endian, zero-filled
instrLinearAddress  out  20  address of the first byte, prefixes included
instrLength  out  LEN_WIDTH  total bytes consumed

Behaviour:
- Reset: all outputs 0; state FETCH_OP; internal counters 0.
- States: FETCH_OP, FETCH_MODRM, FETCH_DISP, FETCH_IMM, GAP, VALID.
- Byte fetch rule, all FETCH_* states:
  - When prefetchEmpty=0 at an edge, latch prefetchTop and drive advanceTop=1 for exactly one cycle.
  - The next cycle is always GAP: advanceTop=0 and no sample, because the queue edge-detects the strobe.
  - Minimum cost is 2 cycles per byte.
  - While prefetchEmpty=1: hold the state, advanceTop=0.
- FETCH_OP:
  - First byte of an instruction latches instrLinearAddress.
  - 26/2E/36/3E set segOverrideValid and segOverride = byte[4:3]; the last one wins.
  - F2/F3 set repPrefix; F0 sets lockPrefix.
  - Any prefix byte increments length and stays in FETCH_OP.
  - Any other byte goes to opcode and lookupOpcode.
- After the opcode's GAP, sample the ROM:
  - lookupModRM=1 -> FETCH_MODRM.
  - Else lookupImmBytes!=0 -> FETCH_IMM.
  - Else -> VALID.
- After ModRM, displacement count:
  - mod=00 & rm=110 -> 2 bytes.
  - mod=01 -> 1 byte.
  - mod=10 -> 2 bytes.
  - mod=11 or other mod=00 -> 0 bytes.
  - Next state: FETCH_DISP if count>0, else FETCH_IMM if immediate count>0, else VALID.
- Displacement and immediate bytes load low byte first. A 1-byte disp is sign-extended to 16 bits. Immediate bytes fill imm[7:0] upward.
- instrLength = prefixes + opcode + modrm + disp + imm bytes, saturating; no wrap.
- VALID:
  - instrValid=1 the cycle after the final byte's GAP, i.e. 2 cycles after the final latch edge.
  - All record fields are stable while instrValid=1; no pops in VALID.
  - instrAccept=1 at an edge -> instrValid=0 next cycle; clear prefixes, modrm, disp, imm and length; go to FETCH_OP.
- flush=1 at an edge, from any state:
  - Go to FETCH_OP, instrValid=0, advanceTop=0, all partial fields cleared.
  - A pop already issued is not undone.
  - flush has priority over instrAccept and over a byte latch in the same cycle.
- RESET has priority over everything, including mid-pop: advanceTop drops to 0 in the next cycle.
- lookupImmBytes values 5..7 are treated as 4.

Test Plan:
- Queue {90}, ROM modrm=0 imm=0 -> one advanceTop pulse; instrValid 2 cycles after the latch; opcode=90, instrLength=1, record fields otherwise 0.
- Queue {2E,8B,47,FE}, ROM modrm=1 imm=0 -> segOverrideValid=1, segOverride=1, opcode=8B, modrm=47, disp=FFFE, instrLength=4, instrLinearAddress = address of the 2E byte, 4 pulses each separated by a low cycle.
- Queue {EA,00,01,00,F0}, ROM modrm=0 imm=4 -> imm=F0000100, instrLength=5, disp=0.
- Queue {F3,A4}, then prefetchEmpty=1 for 10 cycles before {B8,34,12} arrives -> first record repPrefix=11, opcode=A4, length 2; no advanceTop while empty; second record imm=00001234, repPrefix=00, length 3.
- instrAccept held 0 for 6 cycles with instrValid=1 -> fields unchanged, advanceTop stays 0; accept -> instrValid=0 next cycle and the next fetch starts.
- flush asserted in FETCH_DISP of {8B,87,34,..} -> instrValid never rises; next byte C3 yields opcode=C3, length 1, linear address of C3, no stale modrm/disp; RESET mid-pop -> all outputs 0 next cycle.
